// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle control FSM for an RV32I core: sequences fetch/decode/execute/memory/write-back,
// handshakes with instruction and data memories and traps illegal encodings, ECALL and EBREAK.
module rv32i_multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        br_eq,
    input  logic        br_lt,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [2:0]  imm_sel,
    output logic [3:0]  alu_sel,
    output logic        a_sel,
    output logic        b_sel,
    output logic        br_un,
    output logic [1:0]  wb_sel,
    output logic        pc_sel,
    output logic        pc_we,
    output logic        reg_we,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_U   = 3'b011;
    localparam logic [2:0] IMM_J   = 3'b100;
    localparam logic [2:0] IMM_ISH = 3'b110;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_ECALL   = 2'b10;
    localparam logic [1:0] CAUSE_EBREAK  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] trap_cause_reg, trap_cause_next;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // alt selects SUB over ADD and SRA over SRL (instr[30])
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [1:0] dec_cause;

    always_comb begin
        dec_cause = CAUSE_NONE;
        case (opcode)
            OPC_OP: begin
                if (!(funct7 == 7'h00 ||
                      (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))))
                    dec_cause = CAUSE_ILLEGAL;
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b001 && funct7 != 7'h00)
                    dec_cause = CAUSE_ILLEGAL;
                else if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)
                    dec_cause = CAUSE_ILLEGAL;
            end
            OPC_LOAD: begin
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                    dec_cause = CAUSE_ILLEGAL;
            end
            OPC_STORE: begin
                if (funct3 > 3'b010)
                    dec_cause = CAUSE_ILLEGAL;
            end
            OPC_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011)
                    dec_cause = CAUSE_ILLEGAL;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_MISC_MEM: begin
                dec_cause = CAUSE_NONE;
            end
            OPC_SYSTEM: begin
                if (instr == 32'h0000_0073)
                    dec_cause = CAUSE_ECALL;
                else if (instr == 32'h0010_0073)
                    dec_cause = CAUSE_EBREAK;
                else
                    dec_cause = CAUSE_ILLEGAL;
            end
            default: dec_cause = CAUSE_ILLEGAL;
        endcase
    end

    // Datapath selects are a pure function of instr; the FSM only gates when they are visible.
    logic [2:0] imm_d;
    logic [3:0] alu_d;
    logic       a_d, b_d;
    logic [1:0] wb_d;
    logic       is_jump, is_load, is_store, is_branch, is_fence;

    always_comb begin
        imm_d     = IMM_I;
        alu_d     = ALU_ADD;
        a_d       = 1'b0;
        b_d       = 1'b0;
        wb_d      = WB_ALU;
        is_jump   = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_fence  = 1'b0;
        case (opcode)
            OPC_OP: begin
                alu_d = alu_from_f3(funct3, instr[30]);
            end
            OPC_OP_IMM: begin
                b_d   = 1'b1;
                imm_d = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_ISH : IMM_I;
                // instr[30] is immediate data for ADDI etc., so it only selects SRA
                alu_d = alu_from_f3(funct3, (funct3 == 3'b101) && instr[30]);
            end
            OPC_LOAD: begin
                b_d     = 1'b1;
                wb_d    = WB_MEM;
                is_load = 1'b1;
            end
            OPC_STORE: begin
                b_d      = 1'b1;
                imm_d    = IMM_S;
                is_store = 1'b1;
            end
            OPC_LUI: begin
                b_d   = 1'b1;
                imm_d = IMM_U;
                alu_d = ALU_PASSB;
            end
            OPC_AUIPC: begin
                a_d   = 1'b1;
                b_d   = 1'b1;
                imm_d = IMM_U;
            end
            OPC_JAL: begin
                a_d     = 1'b1;
                b_d     = 1'b1;
                imm_d   = IMM_J;
                wb_d    = WB_PC4;
                is_jump = 1'b1;
            end
            OPC_JALR: begin
                b_d     = 1'b1;
                wb_d    = WB_PC4;
                is_jump = 1'b1;
            end
            OPC_BRANCH: begin
                a_d       = 1'b1;
                b_d       = 1'b1;
                imm_d     = IMM_B;
                is_branch = 1'b1;
            end
            OPC_MISC_MEM: begin
                is_fence = 1'b1;
            end
            default: begin
                is_fence = 1'b0;
            end
        endcase
    end

    logic taken;

    always_comb begin
        case (funct3)
            3'b000:         taken = br_eq;
            3'b001:         taken = ~br_eq;
            3'b100, 3'b110: taken = br_lt;
            3'b101, 3'b111: taken = ~br_lt;
            default:        taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            trap_cause_reg <= CAUSE_NONE;
        end else begin
            state_reg      <= state_next;
            trap_cause_reg <= trap_cause_next;
        end
    end

    assign trap_cause = trap_cause_reg;

    always_comb begin
        state_next      = state_reg;
        trap_cause_next = trap_cause_reg;
        imem_req        = 1'b0;
        ir_we           = 1'b0;
        dmem_req        = 1'b0;
        dmem_we         = 1'b0;
        imm_sel         = 3'b000;
        alu_sel         = 4'd0;
        a_sel           = 1'b0;
        b_sel           = 1'b0;
        br_un           = 1'b0;
        wb_sel          = 2'b00;
        pc_sel          = 1'b0;
        pc_we           = 1'b0;
        reg_we          = 1'b0;
        trap            = 1'b0;

        if (state_reg == S_EXEC || state_reg == S_MEM || state_reg == S_WB) begin
            imm_sel = imm_d;
            alu_sel = alu_d;
            a_sel   = a_d;
            b_sel   = b_d;
            wb_sel  = wb_d;
            br_un   = is_branch & instr[13];
        end

        case (state_reg)
            S_IDLE: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we      = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_cause != CAUSE_NONE) begin
                    trap_cause_next = dec_cause;
                    state_next      = S_TRAP;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    pc_we      = 1'b1;
                    pc_sel     = taken;
                    state_next = S_FETCH;
                end else if (is_fence) begin
                    pc_we      = 1'b1;
                    state_next = S_FETCH;
                end else if (is_load || is_store) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready) begin
                    if (is_store) begin
                        pc_we      = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                pc_we      = 1'b1;
                pc_sel     = is_jump;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Scoreboard bench for rv32i_multicycle_ctrl: each driven cycle pushes its expected outputs
// (with a care mask) and the value is popped and compared half a cycle later.
module tb_rv32i_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        br_eq = 1'b0;
    logic        br_lt = 1'b0;
    logic        imem_req, ir_we, dmem_req, dmem_we;
    logic [2:0]  imm_sel;
    logic [3:0]  alu_sel;
    logic        a_sel, b_sel, br_un;
    logic [1:0]  wb_sel;
    logic        pc_sel, pc_we, reg_we, trap;
    logic [1:0]  trap_cause;

    always #5 clk = ~clk;

    rv32i_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .br_eq(br_eq), .br_lt(br_lt),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .imm_sel(imm_sel), .alu_sel(alu_sel), .a_sel(a_sel), .b_sel(b_sel),
        .br_un(br_un), .wb_sel(wb_sel), .pc_sel(pc_sel), .pc_we(pc_we),
        .reg_we(reg_we), .trap(trap), .trap_cause(trap_cause)
    );

    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic       dmem_req;
        logic       dmem_we;
        logic [2:0] imm_sel;
        logic [3:0] alu_sel;
        logic       a_sel;
        logic       b_sel;
        logic       br_un;
        logic [1:0] wb_sel;
        logic       pc_sel;
        logic       pc_we;
        logic       reg_we;
        logic       trap;
        logic [1:0] trap_cause;
    } ctl_t;

    localparam int K_ALU = 0, K_JUMP = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4, K_FENCE = 5;

    int    n_checks = 0;
    int    n_errors = 0;
    ctl_t  exp_q[$];
    ctl_t  mask_q[$];
    string tag_q[$];

    task automatic check_eq(input string tag, input logic [21:0] act, input logic [21:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %06h required %06h", tag, act, exp);
        end else begin
            $display("ok   %s: %06h", tag, act);
        end
    endtask

    function automatic ctl_t en_mask();
        ctl_t m = '0;
        m.imem_req = 1'b1;
        m.ir_we    = 1'b1;
        m.dmem_req = 1'b1;
        m.dmem_we  = 1'b1;
        m.pc_we    = 1'b1;
        m.reg_we   = 1'b1;
        m.trap     = 1'b1;
        return m;
    endfunction

    function automatic ctl_t sel_mask(input logic chk_imm);
        ctl_t m = '0;
        m.alu_sel = '1;
        m.a_sel   = 1'b1;
        m.b_sel   = 1'b1;
        if (chk_imm) m.imm_sel = '1;
        return m;
    endfunction

    // Drive one cycle of inputs, queue its expectation, then sample at the falling edge.
    task automatic step(input string tag, input logic rst, input logic ir, input logic dr,
                        input logic eq, input logic lt, input ctl_t ev, input ctl_t mk);
        ctl_t  obs, e, m;
        string t;
        rst_n      = rst;
        imem_ready = ir;
        dmem_ready = dr;
        br_eq      = eq;
        br_lt      = lt;
        exp_q.push_back(ev);
        mask_q.push_back(mk);
        tag_q.push_back(tag);
        @(negedge clk);
        obs = {imem_req, ir_we, dmem_req, dmem_we, imm_sel, alu_sel, a_sel, b_sel, br_un,
               wb_sel, pc_sel, pc_we, reg_we, trap, trap_cause};
        e = exp_q.pop_front();
        m = mask_q.pop_front();
        t = tag_q.pop_front();
        check_eq(t, obs & m, e & m);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        step({name, " rst"}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, '1);
        step({name, " rst"}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, '1);
        step({name, " idle"}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, '1);
    endtask

    task automatic do_fetch(input string name, input int fw);
        ctl_t ev;
        for (int i = 0; i < fw; i++) begin
            ev = '0;
            ev.imem_req = 1'b1;
            step({name, " fetch-wait"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ev, en_mask());
        end
        ev = '0;
        ev.imem_req = 1'b1;
        ev.ir_we    = 1'b1;
        step({name, " fetch"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ev, en_mask());
        step({name, " decode"}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, en_mask());
    endtask

    task automatic run_instr(input string name, input logic [31:0] ins, input int kind,
                             input int fw, input int mw, input logic eq, input logic lt,
                             input logic taken, input logic [2:0] imm, input logic [3:0] alu,
                             input logic a, input logic b, input logic chk_imm);
        ctl_t sv, sm, ev, mk;
        instr = ins;
        do_fetch(name, fw);
        sv = '0;
        sv.imm_sel = imm;
        sv.alu_sel = alu;
        sv.a_sel   = a;
        sv.b_sel   = b;
        sm = (kind == K_FENCE) ? ctl_t'('0) : sel_mask(chk_imm);
        ev = sv;
        mk = en_mask() | sm;
        if (kind == K_BR) begin
            ev.pc_we  = 1'b1;
            ev.pc_sel = taken;
            ev.br_un  = ins[13];
            mk.pc_sel = 1'b1;
            mk.br_un  = 1'b1;
        end else if (kind == K_FENCE) begin
            ev.pc_we  = 1'b1;
            mk.pc_sel = 1'b1;
        end
        step({name, " exec"}, 1'b1, 1'b1, 1'b1, eq, lt, ev, mk);
        if (kind == K_BR || kind == K_FENCE) return;
        if (kind == K_LOAD || kind == K_STORE) begin
            for (int i = 0; i < mw; i++) begin
                ev = sv;
                ev.dmem_req = 1'b1;
                ev.dmem_we  = (kind == K_STORE);
                step({name, " mem-wait"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ev, en_mask() | sm);
            end
            ev = sv;
            ev.dmem_req = 1'b1;
            ev.dmem_we  = (kind == K_STORE);
            ev.pc_we    = (kind == K_STORE);
            step({name, " mem"}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ev, en_mask() | sm);
            if (kind == K_STORE) return;
        end
        ev = sv;
        ev.reg_we = 1'b1;
        ev.pc_we  = 1'b1;
        ev.wb_sel = (kind == K_LOAD) ? 2'b00 : (kind == K_JUMP) ? 2'b10 : 2'b01;
        ev.pc_sel = (kind == K_JUMP);
        mk = en_mask() | sm;
        mk.wb_sel = '1;
        mk.pc_sel = 1'b1;
        step({name, " wb"}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ev, mk);
    endtask

    task automatic run_trap(input string name, input logic [31:0] ins, input logic [1:0] cause,
                            input int cycles);
        ctl_t ev, mk;
        instr = ins;
        do_fetch(name, 0);
        ev = '0;
        ev.trap       = 1'b1;
        ev.trap_cause = cause;
        mk = en_mask();
        mk.trap_cause = '1;
        for (int i = 0; i < cycles; i++)
            step({name, " trap"}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ev, mk);
    endtask

    initial begin
        ctl_t ev;
        @(posedge clk);
        #1;
        do_reset("por");
        //         name      instr          kind     fw mw eq    lt    tk    imm     alu    a     b     chk_imm
        run_instr("add",   32'h002081B3, K_ALU,   0, 0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0,  1'b0, 1'b0, 1'b0);
        run_instr("lw",    32'h0080A283, K_LOAD,  0, 3, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0,  1'b0, 1'b1, 1'b1);
        run_instr("beq-t", 32'h00208863, K_BR,    0, 0, 1'b1, 1'b0, 1'b1, 3'b010, 4'd0,  1'b1, 1'b1, 1'b1);
        run_instr("beq-n", 32'h00208863, K_BR,    0, 0, 1'b0, 1'b1, 1'b0, 3'b010, 4'd0,  1'b1, 1'b1, 1'b1);
        run_instr("bltu",  32'h0020E463, K_BR,    2, 0, 1'b0, 1'b1, 1'b1, 3'b010, 4'd0,  1'b1, 1'b1, 1'b1);
        run_instr("bge",   32'h0020D463, K_BR,    0, 0, 1'b1, 1'b1, 1'b0, 3'b010, 4'd0,  1'b1, 1'b1, 1'b1);
        run_instr("sw",    32'h0020A423, K_STORE, 0, 1, 1'b0, 1'b0, 1'b0, 3'b001, 4'd0,  1'b0, 1'b1, 1'b1);
        run_instr("srai",  32'h4030D093, K_ALU,   0, 0, 1'b0, 1'b0, 1'b0, 3'b110, 4'd7,  1'b0, 1'b1, 1'b1);
        run_instr("sub",   32'h402081B3, K_ALU,   0, 0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd1,  1'b0, 1'b0, 1'b0);
        run_instr("xor",   32'h0020C1B3, K_ALU,   0, 0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd5,  1'b0, 1'b0, 1'b0);
        run_instr("andi",  32'h0FF0F093, K_ALU,   0, 0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd9,  1'b0, 1'b1, 1'b1);
        run_instr("jal",   32'h008000EF, K_JUMP,  0, 0, 1'b0, 1'b0, 1'b0, 3'b100, 4'd0,  1'b1, 1'b1, 1'b1);
        run_instr("jalr",  32'h000100E7, K_JUMP,  0, 0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0,  1'b0, 1'b1, 1'b1);
        run_instr("lui",   32'h123450B7, K_ALU,   0, 0, 1'b0, 1'b0, 1'b0, 3'b011, 4'd10, 1'b0, 1'b1, 1'b1);
        run_instr("auipc", 32'h00001097, K_ALU,   0, 0, 1'b0, 1'b0, 1'b0, 3'b011, 4'd0,  1'b1, 1'b1, 1'b1);
        run_instr("fence", 32'h0000000F, K_FENCE, 0, 0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0,  1'b0, 1'b0, 1'b0);
        run_trap("ill-ffff", 32'hFFFFFFFF, 2'b01, 20);

        // Reset asserted while a load waits on data memory
        do_reset("r1");
        instr = 32'h0080A283;
        do_fetch("lw-abort", 0);
        ev = '0;
        step("lw-abort exec", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ev, en_mask());
        ev.dmem_req = 1'b1;
        step("lw-abort mem-wait", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ev, en_mask());
        step("lw-abort mem-wait", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ev, en_mask());
        step("lw-abort rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '1);
        step("lw-abort rst", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, '1);
        step("lw-abort idle", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, '1);
        run_instr("add2", 32'h002081B3, K_ALU, 0, 0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
        run_trap("ecall", 32'h00000073, 2'b10, 4);

        do_reset("r2");
        run_trap("ebreak", 32'h00100073, 2'b11, 4);
        do_reset("r3");
        run_trap("ill-op-f7", 32'h402091B3, 2'b01, 3);
        do_reset("r4");
        run_trap("ill-slli", 32'h40109093, 2'b01, 3);
        do_reset("r5");
        run_trap("ill-sd", 32'h0020B423, 2'b01, 3);
        do_reset("r6");
        run_trap("ill-ld-f3", 32'h0000B003, 2'b01, 3);
        do_reset("r7");
        run_trap("ill-br-f3", 32'h0020A463, 2'b01, 3);
        do_reset("r8");
        run_trap("ill-csr", 32'h34011073, 2'b01, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
